// File: rtl/k6502_rmw_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | k6502_rmw_seq                                                               |
// | Read-modify-write sequencer: bus read, one ALU pass, optional write-back,  |
// | then a status-register update strobe.                                      |
// | Optional feature: RMW_DUMMY_WRITE_EN (NMOS-style dummy write of operand).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module k6502_rmw_seq #(
  parameter int         ADDR_W = 16,
  parameter logic [3:0] OP_INC = 4'h3,
  parameter logic [3:0] OP_TST = 4'hB
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  output logic [3:0]        alu_op,
  output logic [1:0]        alu_arg_sel,
  output logic [7:0]        alu_operand,
  input  logic [7:0]        alu_result,
  input  logic [7:0]        alu_sr,
  output logic              sr_we,
  output logic [7:0]        sr_mask,
  output logic [7:0]        sr_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_MODIFY = 3'd2,
`ifdef RMW_DUMMY_WRITE_EN
    S_DUMMY  = 3'd3,
`endif
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_op;
  logic [7:0] r_result;
  logic       w_accept;
  logic       w_enter_wr;

  assign busy     = (r_state != S_IDLE);
  assign w_accept = (r_state == S_IDLE) && start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_next = S_READ;
      S_READ:   if (mem_ready) w_state_next = S_MODIFY;
      S_MODIFY: begin
        if (r_op == OP_TST) begin
          w_state_next = S_DONE;
        end else begin
`ifdef RMW_DUMMY_WRITE_EN
          w_state_next = S_DUMMY;
`else
          w_state_next = S_WRITE;
`endif
        end
      end
`ifdef RMW_DUMMY_WRITE_EN
      S_DUMMY:  if (mem_ready) w_state_next = S_WRITE;
`endif
      S_WRITE:  if (mem_ready) w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

`ifdef RMW_DUMMY_WRITE_EN
  assign w_enter_wr = (w_state_next == S_DUMMY) || (w_state_next == S_WRITE);
`else
  assign w_enter_wr = (w_state_next == S_WRITE);
`endif

  // Strobes are decoded from the next state so every output stays registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done        <= 1'b0;
      sr_we       <= 1'b0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 8'h00;
      alu_op      <= 4'h0;
      alu_arg_sel <= 2'b00;
      alu_operand <= 8'h00;
      sr_mask     <= 8'h00;
      sr_data     <= 8'h00;
      r_op        <= 4'h0;
      r_result    <= 8'h00;
    end else begin
      mem_rd <= (w_state_next == S_READ);
      mem_wr <= w_enter_wr;
      done   <= (w_state_next == S_DONE);
      sr_we  <= (w_state_next == S_DONE);

      if (w_accept) begin
        mem_addr <= addr;
        r_op     <= op;
        sr_mask  <= ((op == OP_INC) || (op == OP_TST)) ? 8'h82 : 8'hC3;
      end

      if ((r_state == S_READ) && mem_ready) begin
        alu_operand <= mem_rdata;
      end

      if (w_state_next == S_MODIFY) begin
        alu_op      <= r_op;
        alu_arg_sel <= 2'b11;
      end

      if (r_state == S_MODIFY) begin
        r_result <= alu_result;
        sr_data  <= alu_sr;
      end

      // Write data is loaded on entry to each write phase and then held.
`ifdef RMW_DUMMY_WRITE_EN
      if ((r_state == S_MODIFY) && (w_state_next == S_DUMMY)) begin
        mem_wdata <= alu_operand;
      end else if ((r_state == S_DUMMY) && (w_state_next == S_WRITE)) begin
        mem_wdata <= r_result;
      end
`else
      if ((r_state == S_MODIFY) && (w_state_next == S_WRITE)) begin
        mem_wdata <= alu_result;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_k6502_rmw_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_k6502_rmw_seq                                                            |
// | Scoreboard bench: ALU and memory environment plus bus-event reference.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_k6502_rmw_seq;

  localparam int         ADDR_W = 16;
  localparam logic [3:0] OP_INC = 4'h3;
  localparam logic [3:0] OP_TST = 4'hB;
`ifdef RMW_DUMMY_WRITE_EN
  localparam int BASE_LAT = 5;
  localparam bit DUMMY_EN = 1'b1;
`else
  localparam int BASE_LAT = 4;
  localparam bit DUMMY_EN = 1'b0;
`endif
  localparam int K_RD   = 0;
  localparam int K_WR   = 1;
  localparam int K_DONE = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [3:0]        op = 4'h0;
  logic [ADDR_W-1:0] addr = '0;
  logic              busy, done, mem_rd, mem_wr, sr_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata, alu_operand, sr_mask, sr_data;
  logic [7:0]        mem_rdata = 8'h00;
  logic              mem_ready = 1'b1;
  logic [3:0]        alu_op;
  logic [1:0]        alu_arg_sel;
  logic [7:0]        alu_result, alu_sr;

  typedef struct {
    int          kind;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  sr;
    logic [7:0]  mask;
    logic [3:0]  f;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   rdy_mode = 0;
  int   rd_stall = 0;
  int   wr_stall = 0;
  logic [7:0] stall_wdata = 8'h00;
  logic [7:0] cur_rdata = 8'h00;

  k6502_rmw_seq #(.ADDR_W(ADDR_W), .OP_INC(OP_INC), .OP_TST(OP_TST)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .addr(addr),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .alu_op(alu_op), .alu_arg_sel(alu_arg_sel),
    .alu_operand(alu_operand), .alu_result(alu_result), .alu_sr(alu_sr),
    .sr_we(sr_we), .sr_mask(sr_mask), .sr_data(sr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU behaviour: {flags, result}. INC/TST set N,Z; other ops add {f,f} and set N,V,Z,C.
  function automatic logic [15:0] alu_ref(input logic [3:0] f, input logic [7:0] x);
    logic [8:0] s;
    logic [7:0] k, r, fl;
    k = {f, f};
    if (f == OP_INC) begin
      r  = x + 8'd1;
      fl = {r[7], 5'b0, (r == 8'h00), 1'b0};
    end else if (f == OP_TST) begin
      r  = x;
      fl = {r[7], 5'b0, (r == 8'h00), 1'b0};
    end else begin
      s  = {1'b0, x} + {1'b0, k};
      r  = s[7:0];
      fl = {r[7], (x[7] == k[7]) && (r[7] != x[7]), 4'b0, (r == 8'h00), s[8]};
    end
    return {fl, r};
  endfunction

  always_comb begin
    {alu_sr, alu_result} = 16'hA55A;
    if (alu_arg_sel == 2'b11) {alu_sr, alu_result} = alu_ref(alu_op, alu_operand);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Memory side: mem_ready policy and read data, updated just after each rising edge.
  initial begin
    logic rdy;
    forever begin
      @(posedge clk);
      #2;
      rdy = 1'b1;
      if (rdy_mode == 1) begin
        rdy = ($urandom_range(0, 2) != 0);
      end else if (rdy_mode == 2) begin
        if (mem_rd && rd_stall > 0) begin
          rdy = 1'b0;
          rd_stall--;
        end else if (mem_wr && mem_wdata == stall_wdata && wr_stall > 0) begin
          rdy = 1'b0;
          wr_stall--;
        end
      end
      mem_ready = rdy;
      mem_rdata = rdy ? cur_rdata : ~cur_rdata;
    end
  end

  // Monitor: pops the scoreboard on every completed bus transfer and on done.
  initial begin
    exp_t e;
    logic prev_wait;
    logic [25:0] prev_snap;
    prev_wait = 1'b0;
    prev_snap = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_wait = 1'b0;
      end else begin
        if (mem_rd && mem_wr) chk("rd_wr_overlap", 64'({mem_rd, mem_wr}), 64'(2'b00));
        if (prev_wait) chk("stable_while_wait", 64'({mem_rd, mem_wr, mem_addr, mem_wdata}), 64'(prev_snap));
        prev_wait = (mem_rd || mem_wr) && !mem_ready;
        prev_snap = {mem_rd, mem_wr, mem_addr, mem_wdata};
        if ((mem_rd || mem_wr) && mem_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_bus_cycle", 64'({mem_rd, mem_wr, mem_addr}), 64'(0));
          end else begin
            e = q.pop_front();
            chk("bus_kind", 64'(mem_wr ? K_WR : K_RD), 64'(e.kind));
            chk("mem_addr", 64'(mem_addr), 64'(e.a));
            if (mem_wr) chk("mem_wdata", 64'(mem_wdata), 64'(e.d));
          end
        end
        if (done) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 64'(done), 64'(0));
          end else begin
            e = q.pop_front();
            chk("done_order", 64'(e.kind), 64'(K_DONE));
            chk("sr_we", 64'(sr_we), 64'(1));
            chk("sr_data", 64'(sr_data), 64'(e.sr));
            chk("sr_mask", 64'(sr_mask), 64'(e.mask));
            chk("alu_op", 64'(alu_op), 64'(e.f));
            chk("alu_arg_sel", 64'(alu_arg_sel), 64'(2'b11));
            chk("alu_operand", 64'(alu_operand), 64'(e.d));
            if (e.lat > 0) chk("latency", 64'(cyc - start_cyc), 64'(e.lat));
          end
        end else if (sr_we) begin
          chk("sr_we_without_done", 64'(sr_we), 64'(0));
        end
      end
    end
  end

  // Pushes the expected bus/done events for one sequence, then pulses start.
  task automatic issue(input logic [3:0] f, input logic [15:0] a, input logic [7:0] x, input int lat);
    logic [15:0] r;
    exp_t e;
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (busy) chk("idle_timeout", 64'(busy), 64'(0));
    r = alu_ref(f, x);
    e = '{kind: K_RD, a: a, d: x, sr: 8'h00, mask: 8'h00, f: f, lat: 0};
    q.push_back(e);
    if (f != OP_TST) begin
      if (DUMMY_EN) begin
        e.kind = K_WR;
        e.d = x;
        q.push_back(e);
      end
      e.kind = K_WR;
      e.d = r[7:0];
      q.push_back(e);
    end
    e.kind = K_DONE;
    e.d = x;
    e.sr = r[15:8];
    e.mask = ((f == OP_INC) || (f == OP_TST)) ? 8'h82 : 8'hC3;
    e.lat = lat;
    q.push_back(e);
    cur_rdata = x;
    op = f;
    addr = a;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #2;
    start = 1'b0;
    op = 4'($urandom);
    addr = 16'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || q.size() != 0) && n < 300) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (busy || q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_strobes", 64'({busy, done, mem_rd, mem_wr, sr_we}), 64'(0));
    chk("reset_bus_data", 64'({mem_addr, mem_wdata, alu_operand}), 64'(0));
    chk("reset_alu_sr", 64'({sr_data, sr_mask, alu_op, alu_arg_sel}), 64'(0));
    reset_n = 1'b1;
    @(posedge clk);
    #2;

    rdy_mode = 0;
    issue(OP_INC, 16'h0200, 8'h41, BASE_LAT);
    wait_idle();
    issue(OP_INC, 16'h1234, 8'hFF, BASE_LAT);
    wait_idle();
    issue(OP_TST, 16'h00F0, 8'h80, 3);
    wait_idle();

    // Stalls: two cycles in the read, one on the result write.
    rdy_mode = 2;
    rd_stall = 2;
    wr_stall = 1;
    stall_wdata = 8'h42;
    issue(OP_INC, 16'h0300, 8'h41, BASE_LAT + 3);
    wait_idle();

    // start during READ and on the DONE cycle must both be ignored.
    rd_stall = 3;
    wr_stall = 0;
    issue(OP_INC, 16'h0400, 8'h10, BASE_LAT + 3);
    start = 1'b1;
    addr = 16'hBEEF;
    @(posedge clk);
    #2;
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_idle();
    repeat (4) @(posedge clk);
    #2;
    chk("no_extra_sequence", 64'(busy), 64'(0));

    // Asynchronous reset while the result write is stalled.
    rdy_mode = 2;
    rd_stall = 0;
    wr_stall = 6;
    stall_wdata = 8'h56;
    issue(OP_INC, 16'h0500, 8'h55, 0);
    n = 0;
    while (!(mem_wr && mem_wdata == 8'h56) && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("reached_write", 64'({mem_wr, mem_wdata}), 64'({1'b1, 8'h56}));
    #1;
    reset_n = 1'b0;
    q.delete();
    #1;
    chk("async_rst_strobes", 64'({busy, done, mem_rd, mem_wr, sr_we}), 64'(0));
    chk("async_rst_bus_data", 64'({mem_addr, mem_wdata, alu_operand}), 64'(0));
    chk("async_rst_alu_sr", 64'({sr_data, sr_mask, alu_op, alu_arg_sel}), 64'(0));
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    rdy_mode = 0;
    wr_stall = 0;
    issue(OP_INC, 16'h0600, 8'h7F, BASE_LAT);
    wait_idle();

    // Randomized sequences with random bus stalls and ignored start pulses.
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      logic [3:0] f;
      case ($urandom_range(0, 3))
        0:       f = OP_INC;
        1:       f = OP_TST;
        default: f = 4'($urandom);
      endcase
      issue(f, 16'($urandom), 8'($urandom), 0);
      if ($urandom_range(0, 3) == 0) begin
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #2;
    end
    wait_idle();
    chk("queue_drained", 64'(q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/k6502_rmw_seq.md
# k6502_rmw_seq

Read-modify-write sequencer for the k6502 core's ALU. It accepts a one-cycle request naming an address and an ALU operation, then performs the bus read and the ALU pass. For write-back ops it also performs the bus write, or the 6502-style dummy write followed by the real write. It finishes with a status-register update strobe. It sits between the instruction decoder (requester) and the `alu`/memory bus, and owns `alu_op`/`alu_arg_sel` for the duration of a sequence.

## Interface
Parameters:
- `ADDR_W`, 16, memory address width.

Ports:
- `clk`  in  1  core clock; all state on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe; sampled only in IDLE.
- `op`  in  4  ALU op to apply (`OP_INC`, `OP_TST` from k6502_defs.v; others allowed).
- `addr`  in  ADDR_W  target address; latched with `start`.
- `busy`  out  1  high from the cycle after accepted `start` through DONE.
- `done`  out  1  one-cycle pulse in DONE.
- `mem_addr`  out  ADDR_W  latched address.
- `mem_rd`  out  1  read request.
- `mem_wr`  out  1  write request.
- `mem_wdata`  out  8  write data.
- `mem_rdata`  in  8  read data; valid when `mem_ready` is high.
- `mem_ready`  in  1  completes the current `mem_rd`/`mem_wr`.
- `alu_op`  out  4  to ALU `op`.
- `alu_arg_sel`  out  2  to ALU `arg_sel`.
- `alu_operand`  out  8  latched operand; the top level wires it to both ALU `data_in` and `arg3`.
- `alu_result`  in  8  ALU `data_out`.
- `alu_sr`  in  8  ALU `sr_data`.
- `sr_we`  out  1  status-register write strobe (one cycle).
- `sr_mask`  out  8  bits of `sr_data` to merge into P.
- `sr_data`  out  8  latched flags.

## Operation
- States: IDLE, READ, MODIFY, DUMMY, WRITE, DONE; 3-bit binary encoding.
- IDLE: on `start`=1, latch `addr` and `op`, then go to READ. `start` is ignored in every other state; there is no queueing.
- READ: `mem_rd`=1. Stay in READ until `mem_ready`=1, then latch `mem_rdata` into `alu_operand` and go to MODIFY.
- MODIFY: exactly one cycle. `alu_op`=latched op and `alu_arg_sel`=2'b11. The ALU captures these on the negedge, and the result is valid by the next posedge.
  - On that posedge, latch `alu_result` into the result register and `alu_sr` into `sr_data`.
  - Next state: DONE if op==`OP_TST`; otherwise DUMMY (`RMW_DUMMY_WRITE_EN` defined) or WRITE.
- DUMMY: `mem_wr`=1 with `mem_wdata`=unmodified operand. Hold until `mem_ready`, then go to WRITE.
- WRITE: `mem_wr`=1 with `mem_wdata`=result. Hold until `mem_ready`, then go to DONE.
- DONE: `done`=1 and `sr_we`=1 for one cycle, then return to IDLE.
- `sr_mask`: 8'h82 (N,Z) for `OP_INC`/`OP_TST`; 8'hC3 (N,V,Z,C) for any other op. It is held from latch until the next `start`.
- `mem_rd` and `mem_wr` are never high together. Request, address and data stay stable while waiting on `mem_ready`.
- Reset values: state IDLE; `busy`, `done`, `mem_rd`, `mem_wr`, `sr_we` = 0; `mem_addr`, `mem_wdata`, `alu_operand`, `sr_data`, `sr_mask` = 0; `alu_op`=4'h0; `alu_arg_sel`=2'b00.
- Outside MODIFY, `alu_arg_sel` and `alu_op` hold their last values.

## Timing
- All outputs are registered except `busy`, which is decoded from state (state != IDLE).
- Latencies assume `mem_ready` is tied high and `start` is sampled at edge 0; each latency is the edge at which `done` is first seen high.
  - Write-back op: READ@1, MODIFY@2, DUMMY@3, WRITE@4, DONE@5 → latency 5 with the macro, 4 without.
  - TST: latency 3.
- Each cycle with `mem_ready`=0 in READ, DUMMY or WRITE adds exactly one cycle.
- `start` may be asserted in the same cycle `done` is high; it is ignored. The earliest accepted `start` is the cycle after DONE.
- Asynchronous reset mid-sequence: all strobes drop immediately, state goes to IDLE, and no partial write completes. After release, the first accepted `start` follows normal timing.

## Configuration
- `RMW_DUMMY_WRITE_EN` defined: DUMMY state present; write-back ops issue two writes (original value, then result), matching NMOS 6502 bus behaviour.
- Not defined: DUMMY state is compiled out, MODIFY goes directly to WRITE, and write-back ops issue one write.

## Test plan
- Reset with `reset_n`=0 mid-WRITE while `mem_wr`=1 → `mem_wr`=0 asynchronously; all outputs reach their reset values; state is IDLE.
- `OP_INC` @16'h0200, `mem_rdata`=8'h41, `mem_ready`=1, macro on → writes 8'h41 then 8'h42 to 16'h0200; `done` at edge 5; `sr_we` with `sr_data`=8'h00, `sr_mask`=8'h82.
- `OP_INC`, `mem_rdata`=8'hFF, macro off → single write of 8'h00; `sr_data`=8'h02 (Z); `done` at edge 4.
- `OP_TST`, `mem_rdata`=8'h80 → no `mem_wr`; `sr_data`=8'h80 (N); `done` at edge 3.
- `OP_INC` with `mem_ready` low for 2 cycles in READ and 1 cycle in WRITE, macro off → `done` at edge 7; address and data stable throughout.
- `start` pulsed during READ and again on the DONE cycle → both ignored; only one sequence runs.
